// File: rtl/bird_physics_pkg.sv
// Shared game constants and state encoding for the bird physics, death
// detector and renderer.
//   SCREEN_H / DEAD_TOP / DEAD_BOT : playfield geometry in pixels
//   HEIGHT_W / VEL_W               : height and velocity bus widths
//   bird_state_e                   : IDLE / FLY / FALL / OVER
//   clamp_height()                 : saturate a signed height sum to [0, h_max]
package bird_physics_pkg;

    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned DEAD_TOP = 10;
    localparam int unsigned DEAD_BOT = 420;
    localparam int unsigned HEIGHT_W = 9;
    localparam int unsigned VEL_W    = 6;
    localparam int unsigned SUM_W    = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_FALL = 2'd2,
        ST_OVER = 2'd3
    } bird_state_e;

    // Saturate so an upward move near the top never wraps to the bottom.
    function automatic logic [HEIGHT_W-1:0] clamp_height(
        input logic signed [SUM_W-1:0] sum,
        input logic [HEIGHT_W-1:0]     h_max
    );
        if (sum < 0) begin
            return '0;
        end
        if (sum > $signed({{(SUM_W-HEIGHT_W){1'b0}}, h_max})) begin
            return h_max;
        end
        return sum[HEIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/bird_physics_if.sv
// Bird physics control/status bundle.
//   in_game, flap, is_dead : controls into the physics block
//   height, velocity       : bird top-edge y and signed speed
//   frame_tick, state      : frame pulse and FSM state
// master drives the controls, slave is the physics block.
interface bird_physics_if;
    import bird_physics_pkg::*;

    logic                       in_game;
    logic                       flap;
    logic                       is_dead;
    logic [HEIGHT_W-1:0]        height;
    logic signed [VEL_W-1:0]    velocity;
    logic                       frame_tick;
    bird_state_e                state;

    modport master (
        output in_game, flap, is_dead,
        input  height, velocity, frame_tick, state
    );

    modport slave (
        input  in_game, flap, is_dead,
        output height, velocity, frame_tick, state
    );

endinterface

// File: rtl/bird_physics_flap_sync.sv
// Button synchroniser: 2-FF sync of an asynchronous input followed by a
// rising-edge detector. Reusable for any push button.
//   clk, reset : clock, async active-low reset
//   i_din      : raw asynchronous button level
//   o_rise_c   : one-clock pulse on a synchronised 0->1 transition
module bird_physics_flap_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_rise_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise_c = r_sync & ~r_prev;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion: frame tick generator, gravity, flap impulses,
// post-death fall and freeze.
//   clk, reset : clock, async active-low reset
//   bus        : bird_physics_if.slave (in_game/flap/is_dead in,
//                height/velocity/frame_tick/state out, all registered)
module bird_physics
    import bird_physics_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1_666_667,
    parameter int unsigned START_H     = 200,
    parameter int unsigned FLAP_V      = 8,
    parameter int unsigned GRAV_FRAMES = 2,
    parameter int unsigned V_MAX       = 10,
    parameter int unsigned H_MAX       = 470
) (
    input  logic           clk,
    input  logic           reset,
    bird_physics_if.slave  bus
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GRAV_W = $clog2(GRAV_FRAMES + 1);
    localparam logic signed [VEL_W-1:0] FLAP_VEL  = -(VEL_W'(FLAP_V));
    localparam logic signed [VEL_W-1:0] VEL_MAX_S = VEL_W'(V_MAX);

    logic [TICK_W-1:0]       r_tick_cnt;
    logic                    r_frame_tick;
    logic [GRAV_W-1:0]       r_grav_cnt;
    logic                    r_flap_pend;
    logic [HEIGHT_W-1:0]     r_height;
    logic signed [VEL_W-1:0] r_velocity;
    bird_state_e             r_state;

    logic                    w_flap_rise;
    logic                    w_pend;
    logic                    w_flap_now;
    logic [GRAV_W-1:0]       w_grav_apply;
    logic signed [VEL_W-1:0] w_vel_apply;
    logic signed [SUM_W-1:0] w_sum;
    logic [HEIGHT_W-1:0]     w_height_nxt;

    bird_physics_flap_sync u_flap_sync (
        .clk      (clk),
        .reset    (reset),
        .i_din    (bus.flap),
        .o_rise_c (w_flap_rise)
    );

    // An edge arriving in the tick cycle is folded into that tick.
    assign w_pend = r_flap_pend | w_flap_rise;

    // Per-tick motion candidate: flap impulse or gravity, then clamped height.
    always_comb begin
        w_flap_now   = ((r_state == ST_FLY) || (r_state == ST_IDLE)) && w_pend;
        w_grav_apply = r_grav_cnt + GRAV_W'(1);
        w_vel_apply  = r_velocity;
        if (w_grav_apply == GRAV_W'(GRAV_FRAMES)) begin
            w_grav_apply = '0;
            if (r_velocity < VEL_MAX_S) begin
                w_vel_apply = r_velocity + VEL_W'(1);
            end
        end
        if (w_flap_now) begin
            w_grav_apply = '0;
            w_vel_apply  = FLAP_VEL;
        end
        w_sum        = $signed({{(SUM_W-HEIGHT_W){1'b0}}, r_height}) + SUM_W'(w_vel_apply);
        w_height_nxt = clamp_height(w_sum, HEIGHT_W'(H_MAX));
    end

    // Free-running frame divider; only reset restarts its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt   <= '0;
            r_frame_tick <= 1'b0;
        end else if (r_tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            r_tick_cnt   <= '0;
            r_frame_tick <= 1'b1;
        end else begin
            r_tick_cnt   <= r_tick_cnt + TICK_W'(1);
            r_frame_tick <= 1'b0;
        end
    end

    // Game FSM with height/velocity datapath; leaving the game overrides all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_height    <= HEIGHT_W'(START_H);
            r_velocity  <= '0;
            r_grav_cnt  <= '0;
            r_flap_pend <= 1'b0;
        end else if (!bus.in_game) begin
            r_state     <= ST_IDLE;
            r_height    <= HEIGHT_W'(START_H);
            r_velocity  <= '0;
            r_grav_cnt  <= '0;
            r_flap_pend <= 1'b0;
        end else begin
            if (r_frame_tick) begin
                r_flap_pend <= 1'b0;
            end else if (w_flap_rise) begin
                r_flap_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_frame_tick && w_pend) begin
                        r_state    <= ST_FLY;
                        r_velocity <= w_vel_apply;
                        r_height   <= w_height_nxt;
                        r_grav_cnt <= w_grav_apply;
                    end
                end
                ST_FLY: begin
                    // Death beats a simultaneous flap; the pending flap is dropped.
                    if (bus.is_dead) begin
                        r_state     <= ST_FALL;
                        r_flap_pend <= 1'b0;
                    end else if (r_frame_tick) begin
                        r_velocity <= w_vel_apply;
                        r_height   <= w_height_nxt;
                        r_grav_cnt <= w_grav_apply;
                    end
                end
                ST_FALL: begin
                    if (r_frame_tick) begin
                        r_height   <= w_height_nxt;
                        r_grav_cnt <= w_grav_apply;
                        if (w_height_nxt == HEIGHT_W'(H_MAX)) begin
                            r_state    <= ST_OVER;
                            r_velocity <= '0;
                        end else begin
                            r_velocity <= w_vel_apply;
                        end
                    end
                end
                ST_OVER: begin
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.height     = r_height;
    assign bus.velocity   = r_velocity;
    assign bus.frame_tick = r_frame_tick;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_bird_physics.sv
// Directed self-checking bench for bird_physics with a 4-clock frame.
module tb_bird_physics;
    import bird_physics_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ft_mask;

    bird_physics_if bus ();

    bird_physics #(
        .TICK_DIV    (4),
        .START_H     (200),
        .FLAP_V      (8),
        .GRAV_FRAMES (2),
        .V_MAX       (10),
        .H_MAX       (470)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stop on the sample where frame_tick is high (pre-update values).
    task automatic wait_ft();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 16);
        if (bus.frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout: observed no frame_tick in 16 clks, expected one");
        end
    endtask

    // Stop on the sample right after the next motion update.
    task automatic next_update();
        wait_ft();
        @(negedge clk);
    endtask

    task automatic do_flap();
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
    endtask

    task automatic check_motion(input string tag, input int st, input int h, input int v);
        check({tag, "_state"},  32'(bus.state),    st);
        check({tag, "_height"}, 32'(bus.height),   h);
        check({tag, "_vel"},    32'(bus.velocity), v);
    endtask

    initial begin
        bus.in_game = 1'b0;
        bus.flap    = 1'b0;
        bus.is_dead = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        check_motion("reset", 0, 200, 0);
        check("reset_tick", 32'(bus.frame_tick), 0);

        // Tick on every 4th clock after release.
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ft_mask[k] = bus.frame_tick;
        end
        check("tick_phase", 32'(ft_mask), 'h88);

        // is_dead in IDLE has no effect.
        bus.in_game = 1'b1;
        bus.is_dead = 1'b1;
        next_update();
        bus.is_dead = 1'b0;
        check_motion("idle_dead", 0, 200, 0);

        // First flap starts the game.
        do_flap();
        next_update();
        check_motion("first_flap", 1, 192, -8);
        next_update();
        check_motion("fly_t1", 1, 184, -8);
        next_update();
        check_motion("fly_t2", 1, 177, -7);

        // Gravity climbs 1 per 2 frames and saturates.
        repeat (14) next_update();
        check_motion("grav_v0", 1, 128, 0);
        repeat (20) next_update();
        check_motion("grav_v10", 1, 228, 10);
        repeat (2) next_update();
        check_motion("grav_sat", 1, 248, 10);
        repeat (22) next_update();
        check_motion("near_floor", 1, 468, 10);
        next_update();
        check_motion("floor_clamp", 1, 470, 10);
        next_update();
        check_motion("floor_hold", 1, 470, 10);

        // Two edges in one frame (second in the tick cycle) -> one impulse.
        wait_ft();
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
        @(negedge clk);
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
        next_update();
        check_motion("multi_flap", 1, 462, -8);
        next_update();
        next_update();
        check_motion("multi_flap_t2", 1, 447, -7);

        // Repeated flaps toward the top clamp at 0.
        repeat (55) begin
            do_flap();
            next_update();
        end
        check_motion("top_7", 1, 7, -8);
        do_flap();
        next_update();
        check_motion("top_clamp", 1, 0, -8);
        next_update();
        next_update();
        check_motion("top_grav", 1, 0, -7);

        // Death together with a pending flap on a tick.
        do_flap();
        wait_ft();
        bus.is_dead = 1'b1;
        @(negedge clk);
        bus.is_dead = 1'b0;
        check_motion("death_flap", 2, 0, -7);

        // Flaps ignored while falling.
        do_flap();
        next_update();
        check_motion("fall_noflap", 2, 0, -7);
        repeat (13) next_update();
        check_motion("fall_v0", 2, 0, 0);
        repeat (20) next_update();
        check_motion("fall_v10", 2, 100, 10);
        repeat (36) next_update();
        check_motion("fall_460", 2, 460, 10);
        next_update();
        check_motion("over", 3, 470, 0);
        repeat (2) next_update();
        check_motion("over_hold", 3, 470, 0);

        bus.in_game = 1'b0;
        @(negedge clk);
        check_motion("exit_idle", 0, 200, 0);

        // Restart, die, then reset in the middle of a frame.
        bus.in_game = 1'b1;
        next_update();
        do_flap();
        next_update();
        check_motion("restart", 1, 192, -8);
        bus.is_dead = 1'b1;
        @(negedge clk);
        bus.is_dead = 1'b0;
        next_update();
        check_motion("fall2", 2, 184, -8);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_motion("mid_reset", 0, 200, 0);
        check("mid_reset_tick", 32'(bus.frame_tick), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ft_mask[k] = bus.frame_tick;
        end
        check("tick_phase2", 32'(ft_mask), 'h88);
        check_motion("post_reset", 0, 200, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
